// File: rtl/exe_div.sv
// exe_div: multi-cycle radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// The caller holds I_div_start until O_div_ready pulses. Operands are latched
// when the request is accepted. Magnitudes are divided unsigned and the result
// signs are restored when the last iteration completes.
module exe_div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             I_div_start,
    input  logic             I_signed_div,
    input  logic             I_annul,
    input  logic [WIDTH-1:0] I_dividend,
    input  logic [WIDTH-1:0] I_divisor,
    output logic             O_div_ready,
    output logic [WIDTH-1:0] O_quotient,
    output logic [WIDTH-1:0] O_remainder,
    output logic             O_busy
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             signed_q, signed_d;
    logic             dvd_neg_q, dvd_neg_d;
    logic             dvs_neg_q, dvs_neg_d;

    logic             dvd_neg_in, dvs_neg_in;
    logic [WIDTH-1:0] dvd_abs, dvs_abs;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] rem_step, quo_step;

    // Operand magnitudes; the most negative value maps onto unsigned 2^(WIDTH-1).
    always_comb begin
        dvd_neg_in = I_signed_div & I_dividend[WIDTH-1];
        dvs_neg_in = I_signed_div & I_divisor[WIDTH-1];
        dvd_abs    = dvd_neg_in ? -I_dividend : I_dividend;
        dvs_abs    = dvs_neg_in ? -I_divisor : I_divisor;
    end

    // One restoring step: shift {rem,quo} left, then trial-subtract the divisor on WIDTH+1 bits.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (!diff[WIDTH]) begin
            rem_step = diff[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = shifted[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state and datapath updates for the IDLE/CALC/DONE sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        signed_d    = signed_q;
        dvd_neg_d   = dvd_neg_q;
        dvs_neg_d   = dvs_neg_q;
        case (state_q)
            IDLE: begin
                if (!I_annul && I_div_start) begin
                    signed_d  = I_signed_div;
                    dvd_neg_d = dvd_neg_in;
                    dvs_neg_d = dvs_neg_in;
                    dvs_d     = dvs_abs;
                    quo_d     = dvd_abs;
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (I_divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = I_dividend;
                        state_d     = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (I_annul) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        quotient_d  = (signed_q & (dvd_neg_q ^ dvs_neg_q)) ? -quo_step : quo_step;
                        remainder_d = (signed_q & dvd_neg_q) ? -rem_step : rem_step;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            signed_q    <= 1'b0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            signed_q    <= signed_d;
            dvd_neg_q   <= dvd_neg_d;
            dvs_neg_q   <= dvs_neg_d;
        end
    end

    // Ready and busy decode only registered state, so nothing feeds back combinationally to the caller.
    assign O_div_ready = (state_q == DONE);
    assign O_busy      = (state_q == CALC);
    assign O_quotient  = quotient_q;
    assign O_remainder = remainder_q;

endmodule

// File: tb/tb_exe_div.sv
// tb_exe_div: directed and randomized checks of exe_div against a
// behavioural reference that works from edge numbers and integer arithmetic.
module tb_exe_div;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sgn;
    logic        annul;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        O_div_ready;
    logic [31:0] O_quotient;
    logic [31:0] O_remainder;
    logic        O_busy;

    int checks = 0;
    int errors = 0;

    exe_div #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .I_div_start  (start),
        .I_signed_div (sgn),
        .I_annul      (annul),
        .I_dividend   (dividend),
        .I_divisor    (divisor),
        .O_div_ready  (O_div_ready),
        .O_quotient   (O_quotient),
        .O_remainder  (O_remainder),
        .O_busy       (O_busy)
    );

    // 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // RISC-V division semantics using wide signed integer arithmetic
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endfunction

    // Reference model: an accepted request finishes 32 edges later (same edge for divide-by-zero)
    int          edge_n    = 0;
    int          done_edge = 0;
    bit          in_op     = 1'b0;
    bit          exp_ready = 1'b0;
    bit          exp_busy  = 1'b0;
    logic [31:0] pend_q    = '0;
    logic [31:0] pend_r    = '0;
    logic [31:0] exp_q     = '0;
    logic [31:0] exp_r     = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                in_op     = 1'b0;
                exp_ready = 1'b0;
                exp_busy  = 1'b0;
                exp_q     = '0;
                exp_r     = '0;
            end else begin
                edge_n++;
                if (in_op && edge_n == done_edge + 1) begin
                    in_op = 1'b0;
                end else if (in_op && annul) begin
                    in_op = 1'b0;
                end else if (!in_op && !annul && start) begin
                    ref_div(dividend, divisor, sgn, pend_q, pend_r);
                    done_edge = (divisor == 32'd0) ? edge_n : edge_n + 32;
                    in_op     = 1'b1;
                end
                if (in_op && edge_n == done_edge) begin
                    exp_q = pend_q;
                    exp_r = pend_r;
                end
                exp_ready = in_op && (edge_n == done_edge);
                exp_busy  = in_op && (edge_n < done_edge);
            end
        end
    end

    // Every falling edge, compare all outputs with the model
    initial begin
        forever begin
            @(negedge clk);
            check_output("ready", 32'(O_div_ready), 32'(exp_ready));
            check_output("busy", 32'(O_busy), 32'(exp_busy));
            check_output("quotient", O_quotient, exp_q);
            check_output("remainder", O_remainder, exp_r);
        end
    end

    // Hold start until ready, counting edges and busy cycles; optionally disturb inputs mid-operation
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic s, input bit wiggle,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output int cyc, output int busy_cyc);
        bit done;
        done     = 1'b0;
        dividend = a;
        divisor  = b;
        sgn      = s;
        annul    = 1'b0;
        start    = 1'b1;
        cyc      = 0;
        busy_cyc = 0;
        q        = '0;
        r        = '0;
        while (!done && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (O_busy) busy_cyc++;
            if (O_div_ready) begin
                done  = 1'b1;
                q     = O_quotient;
                r     = O_remainder;
                start = 1'b0;
            end else if (wiggle && O_busy) begin
                dividend = $urandom;
                divisor  = $urandom;
                sgn      = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) start = 1'b0;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            start = 1'b0;
            $display("[TB] FAIL timeout: no ready after %0d cycles, expected one ready pulse", cyc);
        end
    endtask

    // Watchdog so the run always ends
    initial begin
        #1000000;
        errors++;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        logic [31:0] q, r, eq, er, a, b;
        logic        s;
        int          cyc, bc, mode, ready_seen;

        rst = 1'b1; start = 1'b0; sgn = 1'b0; annul = 1'b0; dividend = '0; divisor = '0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset ready", 32'(O_div_ready), 32'd0);
        check_output("reset busy", 32'(O_busy), 32'd0);
        check_output("reset quotient", O_quotient, 32'd0);
        check_output("reset remainder", O_remainder, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        ref_div(32'hFFFF_FFF9, 32'd2, 1'b1, eq, er);
        check_output("model -7/2 quotient", eq, 32'hFFFF_FFFD);
        check_output("model -7/2 remainder", er, 32'hFFFF_FFFF);

        $display("[TB] unsigned 100 / 7");
        apply_stimulus(32'd100, 32'd7, 1'b0, 1'b0, q, r, cyc, bc);
        check_output("100/7 quotient", q, 32'd14);
        check_output("100/7 remainder", r, 32'd2);
        check_output("100/7 latency", 32'(cyc), 32'd33);
        check_output("100/7 busy cycles", 32'(bc), 32'd32);
        @(negedge clk);

        $display("[TB] signed and unsigned -7 / 2");
        apply_stimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, q, r, cyc, bc);
        check_output("s -7/2 quotient", q, 32'hFFFF_FFFD);
        check_output("s -7/2 remainder", r, 32'hFFFF_FFFF);
        @(negedge clk);
        apply_stimulus(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, q, r, cyc, bc);
        check_output("u -7/2 quotient", q, 32'h7FFF_FFFC);
        check_output("u -7/2 remainder", r, 32'd1);
        @(negedge clk);

        $display("[TB] divide by zero");
        apply_stimulus(32'd5, 32'd0, 1'b1, 1'b0, q, r, cyc, bc);
        check_output("s 5/0 quotient", q, 32'hFFFF_FFFF);
        check_output("s 5/0 remainder", r, 32'd5);
        check_output("s 5/0 latency", 32'(cyc), 32'd1);
        check_output("s 5/0 busy cycles", 32'(bc), 32'd0);
        @(negedge clk);
        apply_stimulus(32'd5, 32'd0, 1'b0, 1'b0, q, r, cyc, bc);
        check_output("u 5/0 quotient", q, 32'hFFFF_FFFF);
        check_output("u 5/0 remainder", r, 32'd5);
        check_output("u 5/0 latency", 32'(cyc), 32'd1);
        @(negedge clk);

        $display("[TB] signed overflow");
        apply_stimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, q, r, cyc, bc);
        check_output("ovf quotient", q, 32'h8000_0000);
        check_output("ovf remainder", r, 32'd0);
        check_output("ovf latency", 32'(cyc), 32'd33);

        $display("[TB] annul in the 10th calculation cycle");
        @(negedge clk);
        dividend = 32'd1000; divisor = 32'd3; sgn = 1'b0; start = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        check_output("annul busy", 32'(O_busy), 32'd0);
        ready_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (O_div_ready) ready_seen++;
        end
        check_output("annul ready pulses", 32'(ready_seen), 32'd0);
        check_output("annul quotient kept", O_quotient, 32'h8000_0000);
        check_output("annul remainder kept", O_remainder, 32'd0);

        dividend = 32'd9; divisor = 32'd3; sgn = 1'b0; start = 1'b1; annul = 1'b1;
        repeat (3) @(negedge clk);
        check_output("annul over start busy", 32'(O_busy), 32'd0);
        check_output("annul over start ready", 32'(O_div_ready), 32'd0);
        apply_stimulus(32'd9, 32'd3, 1'b0, 1'b0, q, r, cyc, bc);
        check_output("9/3 quotient", q, 32'd3);
        check_output("9/3 remainder", r, 32'd0);
        check_output("9/3 latency", 32'(cyc), 32'd33);

        $display("[TB] randomized operations");
        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 9));
            a    = $urandom;
            b    = $urandom;
            s    = 1'($urandom_range(0, 1));
            if (mode == 0) begin
                b = 32'd0;
            end else if (mode == 1) begin
                a = 32'h8000_0000; b = 32'hFFFF_FFFF; s = 1'b1;
            end else if (mode <= 3) begin
                b = 32'($urandom_range(1, 15));
                if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            apply_stimulus(a, b, s, mode >= 8, q, r, cyc, bc);
            ref_div(a, b, s, eq, er);
            check_output("random quotient", q, eq);
            check_output("random remainder", r, er);
            if ($urandom_range(0, 4) == 0) begin
                annul = 1'b1;
                @(negedge clk);
                annul = 1'b0;
            end
        end

        $display("[TB] reset in the 20th calculation cycle");
        @(negedge clk);
        apply_stimulus(32'd100, 32'd7, 1'b0, 1'b0, q, r, cyc, bc);
        @(negedge clk);
        dividend = 32'd1000; divisor = 32'd7; sgn = 1'b0; start = 1'b1;
        @(posedge clk);
        repeat (19) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_output("async reset ready", 32'(O_div_ready), 32'd0);
        check_output("async reset busy", 32'(O_busy), 32'd0);
        check_output("async reset quotient", O_quotient, 32'd0);
        check_output("async reset remainder", O_remainder, 32'd0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] back-to-back after reset");
        apply_stimulus(32'd100, 32'd7, 1'b0, 1'b0, q, r, cyc, bc);
        check_output("post-reset quotient", q, 32'd14);
        check_output("post-reset remainder", r, 32'd2);
        check_output("post-reset latency", 32'(cyc), 32'd33);
        apply_stimulus(32'd200, 32'd9, 1'b0, 1'b0, q, r, cyc, bc);
        check_output("b2b quotient", q, 32'd22);
        check_output("b2b remainder", r, 32'd2);
        check_output("b2b latency", 32'(cyc), 32'd34);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
